// File: rtl/aq_spsram_1024x16_arb_pkg.sv
// Shared types for the 1024x16 single-port SRAM arbiter.
// Holds the sweep FSM encoding and the macro idle levels.
package aq_spsram_1024x16_arb_pkg;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Macro controls are active-low; these are the idle levels.
  localparam logic CEN_IDLE  = 1'b1;
  localparam logic GWEN_IDLE = 1'b1;
  localparam logic WEN_IDLE  = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/aq_spsram_arb_2p.sv
// Two-request fixed-priority arbiter with port-1 starvation guard.
// Ports: CLK/RST, en (serving), clr, p0/p1 req in, p0/p1 gnt out.
module aq_spsram_arb_2p
  import aq_spsram_1024x16_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  input  logic clr,
  input  logic p0_req,
  input  logic p1_req,
  output logic p0_gnt,
  output logic p1_gnt
);

  localparam logic [CNT_W-1:0] SMAX =
    CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt;
  logic             frc;

  always_comb begin
    frc    = (cnt == SMAX) & p1_req;
    p1_gnt = en & p1_req & (~p0_req | frc);
    p0_gnt = en & p0_req & ~p1_gnt;
  end

  // Counts consecutive port-1 losses; any gap
  // in port-1 demand restarts the count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (!en || clr || !p1_req || p1_gnt) begin
      cnt <= '0;
    end else if (cnt != SMAX) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/aq_spsram_1024x16_arb.sv
// Zero-fill sweep and two-port arbiter for a 1024x16 SP SRAM.
// Ports: p0/p1 request buses, rdata/rvld, clr_req, sram_* macro pins.
module aq_spsram_1024x16_arb
  import aq_spsram_1024x16_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  input  logic [DATA_WIDTH-1:0] p0_wmask,
  output logic                  p0_gnt,
  output logic                  p0_rvld,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  input  logic [DATA_WIDTH-1:0] p1_wmask,
  output logic                  p1_gnt,
  output logic                  p1_rvld,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  clr_req,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam logic [ADDR_WIDTH-1:0] A_MAX = '1;

  state_t                state;
  state_t                nxt;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] d_q;
  logic                  run;
  logic                  p0_rvld_q;
  logic                  p1_rvld_q;

  assign run = (state == ST_RUN);

  aq_spsram_arb_2p #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .CLK    (CLK),
    .RST    (RST),
    .en     (run),
    .clr    (clr_req),
    .p0_req (p0_req),
    .p1_req (p1_req),
    .p0_gnt (p0_gnt),
    .p1_gnt (p1_gnt)
  );

  always_comb begin
    nxt       = state;
    init_done = 1'b0;
    sram_cen  = CEN_IDLE;
    sram_gwen = GWEN_IDLE;
    sram_wen  = {DATA_WIDTH{WEN_IDLE}};
    sram_a    = a_q;
    sram_d    = d_q;
    case (state)
      ST_WAIT: nxt = ST_INIT;
      ST_INIT: begin
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = '0;
        sram_a    = cnt;
        sram_d    = '0;
        if (cnt == A_MAX) nxt = ST_RUN;
      end
      ST_RUN: begin
        init_done = 1'b1;
        if (clr_req) nxt = ST_INIT;
        unique case (1'b1)
          p1_gnt: begin
            sram_cen  = 1'b0;
            sram_a    = p1_addr;
            sram_d    = p1_wdata;
            sram_gwen = ~p1_we;
            if (p1_we) sram_wen = ~p1_wmask;
          end
          p0_gnt: begin
            sram_cen  = 1'b0;
            sram_a    = p0_addr;
            sram_d    = p0_wdata;
            sram_gwen = ~p0_we;
            if (p0_we) sram_wen = ~p0_wmask;
          end
          default: ;
        endcase
      end
      default: nxt = ST_WAIT;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_WAIT;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (state == ST_INIT && cnt != A_MAX)
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
    end
  end

  // Address/data hold their last driven value
  // on idle cycles.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_q <= '0;
      d_q <= '0;
    end else if (!sram_cen) begin
      a_q <= sram_a;
      d_q <= sram_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      p0_rvld_q <= 1'b0;
      p1_rvld_q <= 1'b0;
    end else begin
      p0_rvld_q <= p0_gnt & ~p0_we;
      p1_rvld_q <= p1_gnt & ~p1_we;
    end
  end

  assign p0_rvld = p0_rvld_q;
  assign p1_rvld = p1_rvld_q;
  assign rdata   = sram_q;

endmodule

// File: tb/tb_aq_spsram_1024x16_arb.sv
// Bench for aq_spsram_1024x16_arb with a behavioural SRAM.
// Vector table plus scoreboard of expected read returns.
module tb_aq_spsram_1024x16_arb;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        p0_req = 0, p0_we = 0;
  logic [9:0]  p0_addr = 0;
  logic [15:0] p0_wdata = 0, p0_wmask = 0;
  logic        p1_req = 0, p1_we = 0;
  logic [9:0]  p1_addr = 0;
  logic [15:0] p1_wdata = 0, p1_wmask = 0;
  logic        clr_req = 0;
  logic        p0_gnt, p0_rvld, p1_gnt, p1_rvld;
  logic        init_done;
  logic [15:0] rdata;
  logic [9:0]  sram_a;
  logic        sram_cen, sram_gwen;
  logic [15:0] sram_wen, sram_d, sram_q;

  always #5 CLK = ~CLK;

  aq_spsram_1024x16_arb dut (
    .CLK       (CLK),
    .RST       (RST),
    .p0_req    (p0_req),
    .p0_we     (p0_we),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p0_wmask  (p0_wmask),
    .p0_gnt    (p0_gnt),
    .p0_rvld   (p0_rvld),
    .p1_req    (p1_req),
    .p1_we     (p1_we),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_wmask  (p1_wmask),
    .p1_gnt    (p1_gnt),
    .p1_rvld   (p1_rvld),
    .rdata     (rdata),
    .clr_req   (clr_req),
    .init_done (init_done),
    .sram_a    (sram_a),
    .sram_cen  (sram_cen),
    .sram_gwen (sram_gwen),
    .sram_wen  (sram_wen),
    .sram_d    (sram_d),
    .sram_q    (sram_q)
  );

  // Behavioural macro: registered read, bit-masked write.
  logic [15:0] mem [1024];
  logic [15:0] q_r;
  assign sram_q = q_r;

  initial begin
    for (int i = 0; i < 1024; i++)
      mem[i] = 16'($urandom);
    q_r = 16'hDEAD;
  end

  always @(posedge CLK) begin
    if (!sram_cen) begin
      if (!sram_gwen)
        mem[sram_a] <= (mem[sram_a] & sram_wen)
                     | (sram_d & ~sram_wen);
      else
        q_r <= mem[sram_a];
    end
  end

  typedef struct {
    logic        port;
    logic [15:0] data;
    int          due;
  } exp_t;

  typedef struct {
    logic        r0, w0;
    logic [9:0]  a0;
    logic [15:0] d0, m0;
    logic        r1, w1;
    logic [9:0]  a1;
    logic [15:0] d1, m1;
    logic        g0, g1;
  } vec_t;

  exp_t        sb [$];
  logic [15:0] ref_mem [1024];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Called once per negedge: checks read returns.
  task automatic mon();
    exp_t e;
    cyc++;
    if (p0_rvld && p1_rvld) begin
      n_vec++;
      n_err++;
      $display("FAIL rvld_both got 11 want one");
    end
    while (sb.size() > 0 && sb[0].due < cyc) begin
      n_vec++;
      n_err++;
      $display("FAIL rvld_missing got 0 want 1 port %0d",
               sb[0].port);
      void'(sb.pop_front());
    end
    if (p0_rvld || p1_rvld) begin
      if (sb.size() == 0 || sb[0].due != cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL rvld_spurious got 1 want 0");
      end else begin
        e = sb.pop_front();
        chk("rvld_port", 32'(p1_rvld), 32'(e.port));
        chk("rdata", 32'(rdata), 32'(e.data));
      end
    end
  endtask

  // Records this cycle's grants into the model.
  task automatic rec();
    exp_t e;
    if (p0_gnt) begin
      if (p0_we)
        ref_mem[p0_addr] = (ref_mem[p0_addr] & ~p0_wmask)
                         | (p0_wdata & p0_wmask);
      else begin
        e.port = 1'b0;
        e.data = ref_mem[p0_addr];
        e.due  = cyc + 1;
        sb.push_back(e);
      end
    end
    if (p1_gnt) begin
      if (p1_we)
        ref_mem[p1_addr] = (ref_mem[p1_addr] & ~p1_wmask)
                         | (p1_wdata & p1_wmask);
      else begin
        e.port = 1'b1;
        e.data = ref_mem[p1_addr];
        e.due  = cyc + 1;
        sb.push_back(e);
      end
    end
  endtask

  task automatic step(input logic eg0,
                      input logic eg1,
                      input string nm);
    @(negedge CLK);
    mon();
    rec();
    chk({nm, "_g0"}, 32'(p0_gnt), 32'(eg0));
    chk({nm, "_g1"}, 32'(p1_gnt), 32'(eg1));
    @(posedge CLK);
    #1;
  endtask

  // Watches a full sweep until init_done rises.
  task automatic sweep_chk(input string nm);
    int  n = 0;
    int  bad = 0;
    int  last = -10;
    int  at = -1;
    logic [9:0] ea = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      mon();
      if (init_done) begin
        at = i;
        for (int k = 0; k < 1024; k++)
          ref_mem[k] = 16'h0000;
        rec();
        break;
      end
      if (p0_gnt || p1_gnt) bad++;
      if (!sram_cen) begin
        if (sram_a !== ea || sram_gwen !== 1'b0 ||
            sram_wen !== 16'h0 || sram_d !== 16'h0)
          bad++;
        ea = ea + 10'd1;
        n++;
        last = i;
      end
      @(posedge CLK);
      #1;
    end
    @(posedge CLK);
    #1;
    chk({nm, "_len"}, 32'(n), 32'd1024);
    chk({nm, "_bad"}, 32'(bad), 32'd0);
    chk({nm, "_done_at"}, 32'(at - last), 32'd1);
  endtask

  function automatic vec_t mk(
    logic r0, logic w0, logic [9:0] a0,
    logic [15:0] d0, logic [15:0] m0,
    logic r1, logic w1, logic [9:0] a1,
    logic [15:0] d1, logic [15:0] m1,
    logic g0, logic g1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0;
    v.d0 = d0; v.m0 = m0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1;
    v.d1 = d1; v.m1 = m1;
    v.g0 = g0; v.g1 = g1;
    return v;
  endfunction

  vec_t tbl [13];

  initial begin
    tbl[0]  = mk(1,0,10'h000,0,0,
                 0,0,0,0,0, 1,0);
    tbl[1]  = mk(1,0,10'h3FF,0,0,
                 0,0,0,0,0, 1,0);
    tbl[2]  = mk(1,1,10'h155,16'hA5C3,16'hFFFF,
                 0,0,0,0,0, 1,0);
    tbl[3]  = mk(1,0,10'h155,0,0,
                 0,0,0,0,0, 1,0);
    tbl[4]  = mk(1,1,10'h002,16'hFFFF,16'hFFFF,
                 0,0,0,0,0, 1,0);
    tbl[5]  = mk(1,1,10'h002,16'h0000,16'h00F0,
                 0,0,0,0,0, 1,0);
    tbl[6]  = mk(1,0,10'h002,0,0,
                 0,0,0,0,0, 1,0);
    tbl[7]  = mk(0,0,0,0,0,
                 1,1,10'h001,16'h1234,16'hFFFF, 0,1);
    tbl[8]  = mk(1,1,10'h003,16'hBEEF,16'h0000,
                 0,0,0,0,0, 1,0);
    tbl[9]  = mk(1,0,10'h003,0,0,
                 0,0,0,0,0, 1,0);
    tbl[10] = mk(1,0,10'h001,0,0,
                 1,0,10'h002,0,0, 1,0);
    tbl[11] = mk(0,0,0,0,0,
                 1,0,10'h002,0,0, 0,1);
    tbl[12] = mk(0,0,0,0,0,
                 0,0,0,0,0, 0,0);

    // Reset held for 3 cycles with a request pending.
    p0_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      mon();
      chk("rst_cen", 32'(sram_cen), 32'd1);
      chk("rst_gwen", 32'(sram_gwen), 32'd1);
      chk("rst_wen", 32'(sram_wen), 32'hFFFF);
      chk("rst_gnt", 32'({p0_gnt, p1_gnt}), 32'd0);
      chk("rst_done", 32'(init_done), 32'd0);
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    sweep_chk("sweep0");
    p0_req = 1'b0;
    step(0, 0, "idle0");

    foreach (tbl[i]) begin
      p0_req   = tbl[i].r0;
      p0_we    = tbl[i].w0;
      p0_addr  = tbl[i].a0;
      p0_wdata = tbl[i].d0;
      p0_wmask = tbl[i].m0;
      p1_req   = tbl[i].r1;
      p1_we    = tbl[i].w1;
      p1_addr  = tbl[i].a1;
      p1_wdata = tbl[i].d1;
      p1_wmask = tbl[i].m1;
      step(tbl[i].g0, tbl[i].g1,
           $sformatf("vec%0d", i));
    end

    // Both ports read continuously: p1 wins every 5th.
    p0_req = 1; p0_we = 0; p0_addr = 10'h155;
    p1_req = 1; p1_we = 0; p1_addr = 10'h002;
    for (int k = 0; k < 12; k++)
      step(k % 5 != 4, k % 5 == 4,
           $sformatf("starve%0d", k));
    p0_req = 0;
    p1_req = 0;
    step(0, 0, "idle1");

    // clr_req alongside a granted p1 read.
    p1_req = 1; p1_we = 0; p1_addr = 10'h002;
    clr_req = 1;
    step(0, 1, "clr");
    p1_req = 0;
    clr_req = 0;
    sweep_chk("sweep1");
    p0_req = 1; p0_we = 0; p0_addr = 10'h155;
    step(1, 0, "rd155");
    p0_req = 0;
    step(0, 0, "idle2");

    // Reset in the middle of a sweep.
    clr_req = 1;
    step(0, 0, "clr2");
    clr_req = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge CLK);
      mon();
      if (!sram_cen && sram_a == 10'd500) break;
      @(posedge CLK);
      #1;
    end
    chk("mid_a", 32'(sram_a), 32'd500);
    RST = 1'b1;
    #1;
    chk("mid_rst_cen", 32'(sram_cen), 32'd1);
    chk("mid_rst_wen", 32'(sram_wen), 32'hFFFF);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    sb.delete();
    sweep_chk("sweep2");
    p1_req = 1; p1_we = 0; p1_addr = 10'h002;
    step(0, 1, "rd002");
    p1_req = 0;
    step(0, 0, "idle3");
    step(0, 0, "idle4");
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aq_spsram_1024x16_arb.md
Name: aq_spsram_1024x16_arb

Overview:
- Access controller and arbiter for one 1024x16 single-port SRAM macro (active-low CEN/GWEN/per-bit WEN, registered address, read data one cycle after access).
- After reset, and on request, it zero-fills the array with a hardware sweep.
- Then it shares the single port between two requesters: port 0 has fixed priority; port 1 has a starvation guard.
- It returns read data with a per-port valid strobe.

Parameters:
ADDR_WIDTH, 10, SRAM address width (depth = 2**ADDR_WIDTH)
DATA_WIDTH, 16, SRAM data width
STARVE_MAX, 4, consecutive port-1 losses that force one port-1 grant (1..15)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous reset, active-high
p0_req  input  1  port 0 access request
p0_we  input  1  port 0 write (1) / read (0)
p0_addr  input  ADDR_WIDTH  port 0 address
p0_wdata  input  DATA_WIDTH  port 0 write data
p0_wmask  input  DATA_WIDTH  port 0 bit write enables, active-high
p0_gnt  output  1  port 0 accepted this cycle
p0_rvld  output  1  port 0 read data valid
p1_req, p1_we, p1_addr, p1_wdata, p1_wmask, p1_gnt, p1_rvld: same as port 0, for port 1
rdata  output  DATA_WIDTH  read data, shared by both ports
clr_req  input  1  pulse: re-run the zero-fill sweep
init_done  output  1  sweep complete, arbiter serving requests
sram_a  output  ADDR_WIDTH  macro address
sram_cen  output  1  macro chip enable, active-low
sram_gwen  output  1  macro global write enable, active-low
sram_wen  output  DATA_WIDTH  macro bit write enables, active-low
sram_d  output  DATA_WIDTH  macro write data
sram_q  input  DATA_WIDTH  macro read data

Behaviour:
- FSM states: WAIT, INIT, RUN. RST forces WAIT, sweep counter 0, starvation counter 0, rvld registers 0.
- While in WAIT (including while RST is high), outputs are: sram_cen=1, sram_gwen=1, sram_wen=all 1, gnt=0, rvld=0, init_done=0.
- WAIT -> INIT on the first clock edge after RST deasserts.
- INIT, one write per cycle: sram_cen=0, sram_gwen=0, sram_wen=0, sram_d=0, sram_a=sweep counter. The counter increments by 1.
- When the counter equals 2**ADDR_WIDTH-1, that write completes, the FSM moves to RUN and the counter clears. Sweep length is exactly 1024 cycles.
- In INIT: gnt=0, init_done=0, and clr_req is ignored.
- RUN: init_done=1. Arbitration is combinational within the same cycle and there is no request backpressure beyond gnt.
  - Force condition: starvation counter = STARVE_MAX and p1_req=1.
  - p1_gnt = p1_req & (!p0_req | force).
  - p0_gnt = p0_req & !p1_gnt.
- Starvation counter:
  - Increments when p1_req=1 and p1_gnt=0, saturating at STARVE_MAX.
  - Clears on any p1_gnt, or on any cycle with p1_req=0.
- A granted access drives sram_cen=0 with sram_a/sram_d taken from the winner.
- Granted read: sram_gwen=1, sram_wen=all 1.
- Granted write: sram_gwen=0, sram_wen=~wmask. A write with wmask=0 is still granted and consumes a cycle, but no bits change.
- No grant: sram_cen=1, sram_gwen=1, sram_wen=all 1. sram_a and sram_d hold their last values.
- Read return: px_rvld=1 exactly one cycle after a granted read by port x, with rdata=sram_q that cycle. At most one rvld is high per cycle. Back-to-back reads give rvld on consecutive cycles.
- Writes produce no rvld.
- clr_req in RUN:
  - Takes effect at the next edge: state goes to INIT and init_done drops.
  - Any request in that same cycle is still arbitrated normally and its rvld is still issued.
  - The starvation counter clears.
- Read-after-write to the same address on consecutive grants returns the new data; the macro is write-then-read consistent across cycles.
- Async RST during INIT or RUN aborts immediately to WAIT. Any pending rvld is dropped and the sweep restarts from 0.

Decomposition:
- Shared package:
  - FSM state encoding (WAIT=2'd0, INIT=2'd1, RUN=2'd2).
  - SRAM active-low idle constants (CEN_IDLE=1, WEN_IDLE=all 1).
- One natural sub-module, aq_spsram_arb_2p: combinational 2-request fixed-priority arbiter plus the starvation counter register.
- Sweep FSM and datapath mux stay in the top level.

Test Plan:
- Reset/init: RST high 3 cycles, then low.
  - sram_cen=0 for exactly 1024 cycles, sram_a 0..1023, sram_wen=0, sram_d=0.
  - init_done rises on the cycle after a=1023.
  - Any p0 read then returns 16'h0000.
- Write/read: p0 write addr 10'h155, wdata 16'hA5C3, wmask 16'hFFFF; next cycle p0 read 10'h155 -> p0_rvld one cycle later, rdata=16'hA5C3.
- Partial write: preload 16'hFFFF at 10'h002, then write 16'h0000 with wmask 16'h00F0 -> read returns 16'hFF0F.
- Starvation: p0_req and p1_req held high for 12 cycles, STARVE_MAX=4 -> grant pattern p0,p0,p0,p0,p1 repeating. p1 wins on cycles 5 and 10.
- Contention read tags: p0 read 10'h001 and p1 read 10'h002 both pending -> rvld order p0 then p1, with correct data on each cycle. rvld is never high on both ports in the same cycle.
- Mid-op disruption:
  - clr_req while a p1 read is granted -> p1_rvld still fires next cycle, then a full 1024-cycle sweep runs and a prior value at 10'h155 reads back 0.
  - RST pulsed mid-sweep at a=500 -> sweep restarts from a=0.
